// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// States: IDLE (arbitrate) | ISSUE (start pulse) | WAIT_BUSY (await ack) | WAIT_DONE (await byte end)
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GRANT_W      = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_lock,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   uart_tx_en,
  output logic [7:0]             uart_tx_data,
  input  logic                   uart_tx_busy,
  output logic [GRANT_W-1:0]     grant_id,
  output logic                   active,
  output logic                   timeout_err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lock_q, lock_d;
  logic [GRANT_W-1:0] last_q, last_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [7:0]         data_q, data_d;

  logic               win_found;
  logic [GRANT_W-1:0] win_id;
  int                 idx;

  // A held lock wins outright; otherwise scan starting just after the last grant.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    if (lock_q && req_valid[last_q]) begin
      win_found = 1'b1;
      win_id    = last_q;
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        idx = (int'(last_q) + i) % NUM_REQ;
        if (!win_found && req_valid[idx]) begin
          win_found = 1'b1;
          win_id    = GRANT_W'(idx);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_d      = lock_q;
    last_d      = last_q;
    grant_d     = grant_q;
    data_d      = data_q;
    req_ready   = '0;
    uart_tx_en  = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (lock_q && !req_valid[last_q]) lock_d = 1'b0;
        if (!uart_tx_busy && win_found) begin
          req_ready[win_id] = 1'b1;
          data_d            = req_data[8*win_id +: 8];
          grant_d           = win_id;
          last_d            = win_id;
          lock_d            = req_lock[win_id];
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        uart_tx_en = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_err = 1'b1;
          lock_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      last_q  <= GRANT_W'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

  assign uart_tx_data = data_q;
  assign grant_id     = grant_q;
  assign active       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected {grant, byte} pushed per scenario,
// popped on every start pulse; a simple uart_tx busy model answers the pulses.
module tb_uart_tx_arbiter;
  localparam int NR = 2;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0] req_lock = '0;
  logic [NR-1:0] req_ready;
  logic          uart_tx_en;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_busy = 1'b0;
  logic [0:0]    grant_id;
  logic          active;
  logic          timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(TO), .GRANT_W(1)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(req_ready),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
    .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [8:0] sb[$];

  int busy_len, busy_left, ignore_en;
  int cyc, en_count, tmo_count, act_count, ready_busy;
  int first_en_cyc, first_tmo_cyc;

  task automatic drive_reqs();
    req_valid[0]  = (src0.size() > 0);
    req_valid[1]  = (src1.size() > 0);
    req_data[7:0]  = (src0.size() > 0) ? src0[0] : 8'h00;
    req_data[15:8] = (src1.size() > 0) ? src1[0] : 8'h00;
  endtask

  task automatic step();
    logic          en_now;
    logic [NR-1:0] acc;
    logic [8:0]    exp;
    @(negedge CLK);
    en_now = uart_tx_en;
    acc    = req_valid & req_ready;
    if (active) act_count++;
    if (uart_tx_busy && (req_ready != '0)) ready_busy++;
    if (timeout_err) begin
      tmo_count++;
      if (first_tmo_cyc < 0) first_tmo_cyc = cyc;
    end
    if (uart_tx_en) begin
      en_count++;
      if (first_en_cyc < 0) first_en_cyc = cyc;
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_en: got grant=%0d data=%h, required no start pulse", grant_id, uart_tx_data);
      end else begin
        exp = sb.pop_front();
        if ({grant_id, uart_tx_data} !== exp) begin
          errors++;
          $display("FAIL tx_byte: got grant=%0d data=%h, required grant=%0d data=%h",
                   grant_id, uart_tx_data, exp[8], exp[7:0]);
        end
      end
    end
    @(posedge CLK);
    #1;
    if (acc[0]) src0.delete(0);
    if (acc[1]) src1.delete(0);
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) uart_tx_busy = 1'b0;
    end
    if (en_now) begin
      if (ignore_en > 0) ignore_en--;
      else if (busy_len > 0) begin
        uart_tx_busy = 1'b1;
        busy_left    = busy_len;
      end
    end
    drive_reqs();
    cyc++;
  endtask

  task automatic do_reset();
    src0.delete(); src1.delete(); sb.delete();
    req_lock = '0; uart_tx_busy = 1'b0;
    busy_len = 0; busy_left = 0; ignore_en = 0;
    drive_reqs();
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    en_count = 0; tmo_count = 0; act_count = 0; ready_busy = 0;
    first_en_cyc = -1; first_tmo_cyc = -1;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    while (!(sb.size() == 0 && src0.size() == 0 && src1.size() == 0 && !active && !uart_tx_busy)) begin
      if (n >= budget) break;
      step();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_budget: got %0d bytes still expected after %0d cycles, required 0", name, sb.size(), n);
    end
    step(); step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(); step();
    vectors++;
    if ({active, uart_tx_en, uart_tx_data, grant_id, timeout_err, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got act=%b en=%b data=%h grant=%0d tmo=%b ready=%b, required all zero",
               active, uart_tx_en, uart_tx_data, grant_id, timeout_err, req_ready);
    end
    RST = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    busy_len = 20;
    src0.push_back(8'h41);
    sb.push_back({1'b0, 8'h41});
    drive_reqs();
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b, required 01", req_ready);
    end
    run_until_idle(100, "single");
    vectors++;
    if (en_count !== 1) begin
      errors++; $display("FAIL single_en_count: got %0d, required 1", en_count);
    end
    vectors++;
    if (act_count !== 22) begin
      errors++; $display("FAIL single_active_cycles: got %0d, required 22", act_count);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    busy_len = 3;
    src0.push_back(8'h10); src0.push_back(8'h10);
    src1.push_back(8'h20); src1.push_back(8'h20);
    sb.push_back({1'b0, 8'h10}); sb.push_back({1'b1, 8'h20});
    sb.push_back({1'b0, 8'h10}); sb.push_back({1'b1, 8'h20});
    drive_reqs();
    run_until_idle(200, "round_robin");
    vectors++;
    if (en_count !== 4) begin
      errors++; $display("FAIL rr_en_count: got %0d, required 4", en_count);
    end
  endtask

  task automatic test_lock();
    do_reset();
    busy_len = 2;
    req_lock = 2'b01;
    src0.push_back(8'h61); src0.push_back(8'h62); src0.push_back(8'h63);
    src1.push_back(8'h7A);
    sb.push_back({1'b0, 8'h61}); sb.push_back({1'b0, 8'h62});
    sb.push_back({1'b0, 8'h63}); sb.push_back({1'b1, 8'h7A});
    drive_reqs();
    run_until_idle(200, "lock");
    vectors++;
    if (en_count !== 4) begin
      errors++; $display("FAIL lock_en_count: got %0d, required 4", en_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    busy_len  = 4;
    ignore_en = 1;
    src0.push_back(8'h55);
    src1.push_back(8'h66);
    sb.push_back({1'b0, 8'h55}); sb.push_back({1'b1, 8'h66});
    drive_reqs();
    run_until_idle(200, "timeout");
    vectors++;
    if (tmo_count !== 1) begin
      errors++; $display("FAIL timeout_pulses: got %0d, required 1", tmo_count);
    end
    vectors++;
    if (first_tmo_cyc - first_en_cyc !== TO) begin
      errors++; $display("FAIL timeout_delay: got %0d, required %0d", first_tmo_cyc - first_en_cyc, TO);
    end
    vectors++;
    if (en_count !== 2) begin
      errors++; $display("FAIL timeout_en_count: got %0d, required 2", en_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    busy_len = 30;
    src0.push_back(8'h33);
    sb.push_back({1'b0, 8'h33});
    drive_reqs();
    for (int i = 0; i < 6; i++) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    vectors++;
    if ({active, uart_tx_en, uart_tx_data} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid: got act=%b en=%b data=%h, required 0 0 00", active, uart_tx_en, uart_tx_data);
    end
    vectors++;
    if (uart_tx_busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid_busy_model: got busy=%b, required 1", uart_tx_busy);
    end
    src1.push_back(8'h46);
    src0.push_back(8'h35);
    sb.push_back({1'b0, 8'h35}); sb.push_back({1'b1, 8'h46});
    drive_reqs();
    run_until_idle(200, "reset_mid");
    vectors++;
    if (en_count !== 3) begin
      errors++; $display("FAIL reset_mid_en_count: got %0d, required 3", en_count);
    end
  endtask

  task automatic test_stray_busy();
    int bad = 0;
    do_reset();
    busy_len = 3;
    uart_tx_busy = 1'b1;
    src0.push_back(8'hA0);
    src1.push_back(8'hB0);
    sb.push_back({1'b0, 8'hA0}); sb.push_back({1'b1, 8'hB0});
    drive_reqs();
    for (int i = 0; i < 6; i++) begin
      #1;
      if (req_ready !== 2'b00 || active !== 1'b0) bad++;
      step();
    end
    vectors++;
    if (bad !== 0) begin
      errors++; $display("FAIL stray_busy_ready: got %0d cycles with ready or active set, required 0", bad);
    end
    uart_tx_busy = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL stray_busy_release: got ready=%b, required 01", req_ready);
    end
    run_until_idle(200, "stray_busy");
  endtask

  initial begin
    busy_len = 0; busy_left = 0; ignore_en = 0; cyc = 0;
    first_en_cyc = -1; first_tmo_cyc = -1;
    test_reset();
    test_single();
    vectors++;
    if (ready_busy !== 0) begin
      errors++; $display("FAIL single_ready_while_busy: got %0d, required 0", ready_busy);
    end
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid();
    vectors++;
    if (ready_busy !== 0) begin
      errors++; $display("FAIL reset_mid_ready_while_busy: got %0d, required 0", ready_busy);
    end
    test_stray_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
